data_mem_subword: RTL and testbench
===================================

Name: data_mem_subword

Overview:
Next-generation data memory for the pipelined MIPS CPU's MEM stage. Supports byte, halfword and word loads/stores with sign/zero extension, big-endian. A valid/ready request handshake with a configurable wait-state count lets the pipeline stall on slow memory. Misaligned and out-of-range accesses are flagged as errors and never touch the array.

Parameters:
BYTES, 1024, memory size in bytes (multiple of 4)
START, 'h10008000, base byte address of the array
WAIT_CYCLES, 0, extra wait cycles before each access commits (0..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted on an edge where req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 halfword, 2 word, 3 invalid
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
address  in  32  byte address
write_data  in  32  store data, LSB-aligned (byte [7:0], half [15:0])
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or invalid size
read_data  out  32  load result, valid with resp_valid

Behaviour:
- Single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, wait counter 0, resp_valid 0, resp_err 0, read_data 0. req_ready is 1 once out of reset. The memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE || state==RESP).
- On accept, latch req_write, req_size, req_signed, address and write_data. Later input changes are ignored.
- Error check at accept:
  - size 3 is an error.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr < START, or addr+nbytes-1 > START+BYTES-1. Compute in 33 bits so wrap-around near 0xFFFFFFFF cannot pass the check.
- Error path: next state RESP with resp_err=1, read_data=0, no write. Latency is 1 edge.
- Good path:
  - Next state WAIT, counter loaded with WAIT_CYCLES.
  - In WAIT, if counter != 0, decrement and stay.
  - If counter == 0, the access commits on that edge: store writes the array, load registers read_data. Next state RESP.
- Latency: accept at edge k, commit at edge k+1+WAIT_CYCLES, resp_valid high in the following cycle only.
- In RESP: resp_valid=1 for exactly one cycle. A new accept goes to WAIT or error-RESP (back-to-back). Otherwise go to IDLE and clear resp_valid and resp_err. read_data holds its last value until the next commit or error.
- Big-endian lanes, with a = latched address:
  - byte: m[a]
  - half: {m[a], m[a+1]}
  - word: {m[a], m[a+1], m[a+2], m[a+3]}
- Stores: byte writes wd[7:0] to m[a]. Half writes wd[15:8] to m[a] and wd[7:0] to m[a+1]. Word writes all four bytes. Other bytes are untouched.
- Loads: byte and half are extended to 32 bits per req_signed. req_signed is ignored for word loads and for stores. read_data is 0 after a store response.
- Reset mid-operation: an access still in WAIT before its commit edge is discarded and the array is unchanged. The FSM returns to IDLE.
- Reads of never-written bytes return X. The bench must pre-write or ignore them.

Decomposition:
- Package dmem_pkg:
  - SZ_BYTE/SZ_HALF/SZ_WORD/SZ_INV size encodings
  - FSM state typedef (IDLE/WAIT/RESP)
  - nbytes-from-size function
- One combinational sub-module, dmem_lane_align: inputs size, signed and the 4 fetched bytes; output the extended 32-bit load value.
- Range/alignment check and FSM stay in the top.

Test Plan:
- Word/sub-word reads, WAIT_CYCLES=0:
  - sw 0x12345678 @0x10008000, then lw → 0x12345678, resp_err=0.
  - lbu @0x10008001 → 0x00000034.
  - lh @0x10008002 → 0x00005678.
- Sub-word store and extension:
  - sb 0x000000FF @0x10008003, then lb → 0xFFFFFFFF.
  - lbu → 0x000000FF.
  - lw @0x10008000 → 0x123456FF.
  - sh 0x00008001 @0x10008000, then lh → 0xFFFF8001 and lw → 0x800156FF.
- Errors:
  - lw @0x10008002 → resp_err=1, read_data=0 one cycle after accept.
  - sw @0x10008400 → resp_err=1, and lw @0x100083FC afterwards still returns its prior value.
  - req_size=3 → resp_err=1.
- Latency, WAIT_CYCLES=2:
  - Accept at edge k → req_ready=0 during cycles k+1..k+3, resp_valid=1 only in the cycle after edge k+3.
  - A second request held valid is accepted in RESP with no IDLE bubble.
- Reset abort: WAIT_CYCLES=3, sw 0xDEADBEEF @0x10008010, rst_n low during WAIT → outputs 0, FSM IDLE, and a later lw @0x10008010 returns the old value.
- Wrap-around guard: lw @0xFFFFFFFC with START=0xFFFFFC00, BYTES=1024 → resp_err=0 and data returned. lh @0xFFFFFFFF → resp_err=1 (misaligned and wraps).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states
// and the byte count of each access size.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_INV  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // SZ_INV reports 4 so range math stays well-defined; it is rejected anyway.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load-result formatter: takes the four big-endian bytes starting at the access
// address (first byte in [31:24]) and returns the sign/zero-extended load value.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] fetched,
    output logic [31:0] load_data
);

    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & fetched[31]}}, fetched[31:24]};
            SZ_HALF: load_data = {{16{sign_ext & fetched[31]}}, fetched[31:16]};
            SZ_WORD: load_data = fetched;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_subword.sv
// Big-endian byte/half/word data memory with a valid/ready request port,
// programmable wait states and error responses for bad accesses.
module data_mem_subword
    import dmem_pkg::*;
#(
    parameter int unsigned BYTES       = 1024,
    parameter logic [31:0] START       = 32'h10008000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] read_data
);

    localparam int          IW   = $clog2(BYTES);
    localparam logic [32:0] LAST = {1'b0, START} + 33'(BYTES) - 33'd1;

    dmem_state_e state;
    logic [7:0]  wait_cnt;

    logic        lat_write;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [IW-1:0] lat_off;
    logic [31:0] lat_wdata;

    logic [7:0]  mem [BYTES];

    logic        accept;
    logic        commit;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] addr_lo;
    logic [32:0] addr_hi;

    logic [IW-1:0] idx0, idx1, idx2, idx3;
    logic [31:0] fetched;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;
    assign commit    = (state == WAIT) && (wait_cnt == 8'd0);

    // 33-bit bounds so an access straddling 0xFFFFFFFF cannot wrap into range.
    assign addr_lo      = {1'b0, address};
    assign addr_hi      = addr_lo + 33'(size_nbytes(req_size)) - 33'd1;
    assign misaligned   = ((req_size == SZ_HALF) && address[0]) ||
                          ((req_size == SZ_WORD) && (address[1:0] != 2'b00));
    assign out_of_range = (addr_lo < {1'b0, START}) || (addr_hi > LAST);
    assign req_err      = (req_size == SZ_INV) || misaligned || out_of_range;

    assign idx0 = lat_off;
    assign idx1 = lat_off + IW'(1);
    assign idx2 = lat_off + IW'(2);
    assign idx3 = lat_off + IW'(3);

    // Lanes past the access width may read unrelated bytes; the aligner drops them.
    assign fetched = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

    dmem_lane_align u_align (
        .size      (lat_size),
        .sign_ext  (lat_signed),
        .fetched   (fetched),
        .load_data (load_data)
    );

    // The array has no reset; a reset during WAIT simply never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && lat_write) begin
            case (lat_size)
                SZ_BYTE: mem[idx0] <= lat_wdata[7:0];
                SZ_HALF: begin
                    mem[idx0] <= lat_wdata[15:8];
                    mem[idx1] <= lat_wdata[7:0];
                end
                default: begin
                    mem[idx0] <= lat_wdata[31:24];
                    mem[idx1] <= lat_wdata[23:16];
                    mem[idx2] <= lat_wdata[15:8];
                    mem[idx3] <= lat_wdata[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            read_data  <= '0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_off    <= '0;
            lat_wdata  <= '0;
        end else begin
            if (accept) begin
                lat_write  <= req_write;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_off    <= IW'(address - START);
                lat_wdata  <= write_data;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept && req_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        read_data  <= '0;
                    end else if (accept) begin
                        state      <= WAIT;
                        wait_cnt   <= 8'(WAIT_CYCLES);
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        read_data  <= lat_write ? 32'h0 : load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_subword.sv
// Bench for data_mem_subword: four instances (0/2/3 wait states and a top-of-
// address-space window) driven by directed ops and checked against a byte model.
module tb_data_mem_subword;

    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;
    localparam logic [1:0] SI = 2'd3;
    localparam int unsigned NB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, req_write, req_signed, resp_valid, resp_err;
    logic [1:0]  req_size   [4];
    logic [31:0] address    [4];
    logic [31:0] write_data [4];
    logic [31:0] read_data  [4];

    int total = 0;
    int bad   = 0;

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_subword #(
            .BYTES       (NB),
            .START       ((g == 3) ? 32'hFFFFFC00 : 32'h10008000),
            .WAIT_CYCLES ((g == 1) ? 2 : (g == 2) ? 3 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_size   (req_size[g]),
            .req_signed (req_signed[g]),
            .address    (address[g]),
            .write_data (write_data[g]),
            .resp_valid (resp_valid[g]),
            .resp_err   (resp_err[g]),
            .read_data  (read_data[g])
        );
    end

    function automatic int unsigned wc_of(input int d);
        return (d == 1) ? 2 : (d == 2) ? 3 : 0;
    endfunction

    function automatic logic [31:0] start_of(input int d);
        return (d == 3) ? 32'hFFFFFC00 : 32'h10008000;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mm [bit [33:0]];

    function automatic bit model_err(input int d, input logic [31:0] a, input logic [1:0] sz);
        longint unsigned lo, hi, s;
        int n;
        if (sz == SI) return 1'b1;
        n = nbytes(sz);
        if ((a % n) != 0) return 1'b1;
        lo = a;
        s  = start_of(d);
        hi = lo + n - 1;
        return (lo < s) || (hi > s + NB - 1);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        logic [1:0]  dd;
        int n;
        dd = 2'(d);
        n  = nbytes(sz);
        v  = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mm[{dd, 32'(a + i)}]};
        if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input int d, input logic [31:0] a,
                               input logic [1:0] sz, input logic [31:0] wd);
        logic [1:0] dd;
        int n;
        dd = 2'(d);
        n  = nbytes(sz);
        for (int i = 0; i < n; i++) mm[{dd, 32'(a + i)}] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    bit          m_pend [4];
    int          m_rem  [4];
    bit          m_err  [4];
    bit          m_wr   [4];
    bit          m_sg   [4];
    logic [1:0]  m_sz   [4];
    logic [31:0] m_a    [4];
    logic [31:0] m_wd   [4];
    bit          m_rdy  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Inputs change only 1 time unit after a falling edge, so what is seen here
    // is what the DUT saw on the rising edge just passed.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            bit          ev;
            bit          ee;
            logic [31:0] ed;
            ev = 1'b0;
            ee = 1'b0;
            ed = 32'h0;
            if (!rst_n) begin
                m_pend[d] = 1'b0;
                m_rdy[d]  = 1'b1;
                chk($sformatf("m%0d_rst_ready", d), 32'(req_ready[d]), 32'd1);
                chk($sformatf("m%0d_rst_valid", d), 32'(resp_valid[d]), 32'd0);
                chk($sformatf("m%0d_rst_err", d), 32'(resp_err[d]), 32'd0);
                chk($sformatf("m%0d_rst_data", d), read_data[d], 32'h0);
            end else begin
                if (m_pend[d]) m_rem[d]--;
                if (req_valid[d] && m_rdy[d]) begin
                    m_pend[d] = 1'b1;
                    m_wr[d]   = req_write[d];
                    m_sg[d]   = req_signed[d];
                    m_sz[d]   = req_size[d];
                    m_a[d]    = address[d];
                    m_wd[d]   = write_data[d];
                    m_err[d]  = model_err(d, address[d], req_size[d]);
                    m_rem[d]  = m_err[d] ? 0 : int'(wc_of(d)) + 1;
                end
                if (m_pend[d] && m_rem[d] == 0) begin
                    m_pend[d] = 1'b0;
                    ev = 1'b1;
                    ee = m_err[d];
                    if (!ee && m_wr[d]) model_store(d, m_a[d], m_sz[d], m_wd[d]);
                    else if (!ee) ed = model_load(d, m_a[d], m_sz[d], m_sg[d]);
                end
                m_rdy[d] = !m_pend[d];
                chk($sformatf("m%0d_ready", d), 32'(req_ready[d]), 32'(m_rdy[d]));
                chk($sformatf("m%0d_valid", d), 32'(resp_valid[d]), 32'(ev));
                if (ev) begin
                    chk($sformatf("m%0d_err", d), 32'(resp_err[d]), 32'(ee));
                    chk($sformatf("m%0d_data", d), read_data[d], ed);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        address[d]    = a;
        write_data[d] = wd;
        req_valid[d]  = 1'b1;
    endtask

    task automatic wait_accept(input int d, input string nm);
        int n;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_accept_in_time"}, 32'(n < 50), 32'd1);
        tick();
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input string nm, output int lat);
        lat = 0;
        while (!resp_valid[d] && lat < 50) begin
            tick();
            lat++;
        end
        chk({nm, "_resp_in_time"}, 32'(lat < 50), 32'd1);
    endtask

    // lat = falling edges between the accepting rising edge and resp_valid.
    task automatic op(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit xerr, input logic [31:0] xdata, input int xlat, input string nm);
        int lat;
        drive(d, wr, sz, sg, a, wd);
        wait_accept(d, nm);
        wait_resp(d, nm, lat);
        chk({nm, "_err"}, 32'(resp_err[d]), 32'(xerr));
        chk({nm, "_data"}, read_data[d], xdata);
        chk({nm, "_lat"}, 32'(lat), 32'(xlat));
        tick();
    endtask

    initial begin
        int n;
        int lat;
        req_valid  = '0;
        req_write  = '0;
        req_signed = '0;
        for (int d = 0; d < 4; d++) begin
            req_size[d]   = SB;
            address[d]    = 32'h0;
            write_data[d] = 32'h0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_ready%0d", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("reset_valid%0d", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("reset_data%0d", d), read_data[d], 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // zero wait states: word and sub-word traffic
        op(0, 1, SW, 0, 32'h10008000, 32'h12345678, 0, 32'h0,        1, "sw_base");
        op(0, 0, SW, 0, 32'h10008000, 32'h0,        0, 32'h12345678, 1, "lw_base");
        op(0, 0, SB, 0, 32'h10008001, 32'h0,        0, 32'h00000034, 1, "lbu_1");
        op(0, 0, SH, 1, 32'h10008002, 32'h0,        0, 32'h00005678, 1, "lh_2");
        op(0, 1, SB, 0, 32'h10008003, 32'h000000FF, 0, 32'h0,        1, "sb_3");
        op(0, 0, SB, 1, 32'h10008003, 32'h0,        0, 32'hFFFFFFFF, 1, "lb_3");
        op(0, 0, SB, 0, 32'h10008003, 32'h0,        0, 32'h000000FF, 1, "lbu_3");
        op(0, 0, SW, 0, 32'h10008000, 32'h0,        0, 32'h123456FF, 1, "lw_after_sb");
        op(0, 1, SH, 1, 32'h10008000, 32'h00008001, 0, 32'h0,        1, "sh_0");
        op(0, 0, SH, 1, 32'h10008000, 32'h0,        0, 32'hFFFF8001, 1, "lh_0");
        op(0, 0, SH, 0, 32'h10008000, 32'h0,        0, 32'h00008001, 1, "lhu_0");
        op(0, 0, SW, 0, 32'h10008000, 32'h0,        0, 32'h800156FF, 1, "lw_after_sh");

        // error responses arrive one edge after accept with zero data
        op(0, 0, SW, 0, 32'h10008002, 32'h0,        1, 32'h0,        0, "lw_misal");
        op(0, 1, SW, 0, 32'h100083FC, 32'hCAFEF00D, 0, 32'h0,        1, "sw_top");
        op(0, 1, SW, 0, 32'h10008400, 32'h0BADBAD0, 1, 32'h0,        0, "sw_oor");
        op(0, 0, SW, 0, 32'h100083FC, 32'h0,        0, 32'hCAFEF00D, 1, "lw_top_kept");
        op(0, 0, SI, 0, 32'h10008000, 32'h0,        1, 32'h0,        0, "size_inv");
        op(0, 0, SB, 0, 32'h10007FFF, 32'h0,        1, 32'h0,        0, "lb_below");
        op(0, 0, SH, 0, 32'h10008001, 32'h0,        1, 32'h0,        0, "lh_misal");

        // two wait states: latency and back-to-back accept from RESP
        op(1, 1, SW, 0, 32'h10008020, 32'hA5A50001, 0, 32'h0,        3, "w2_sw");
        drive(1, 1, SW, 0, 32'h10008024, 32'h11223344);
        wait_accept(1, "b2b_a");
        req_valid[1] = 1'b1;
        drive(1, 0, SW, 0, 32'h10008024, 32'h0);
        n = 0;
        while (!req_ready[1] && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_busy_cycles", 32'(n), 32'd3);
        chk("b2b_resp_with_ready", 32'(resp_valid[1]), 32'd1);
        chk("b2b_a_err", 32'(resp_err[1]), 32'd0);
        wait_accept(1, "b2b_b");
        chk("b2b_pulse_cleared", 32'(resp_valid[1]), 32'd0);
        wait_resp(1, "b2b_b", lat);
        chk("b2b_b_data", read_data[1], 32'h11223344);
        chk("b2b_b_lat", 32'(lat), 32'd3);
        tick();
        op(1, 0, SH, 1, 32'h10008020, 32'h0,        0, 32'hFFFFA5A5, 3, "w2_lh");

        // three wait states: reset while in WAIT discards the store
        op(2, 1, SW, 0, 32'h10008010, 32'h01020304, 0, 32'h0,        4, "w3_sw_old");
        op(2, 0, SW, 0, 32'h10008010, 32'h0,        0, 32'h01020304, 4, "w3_lw_old");
        drive(2, 1, SW, 0, 32'h10008010, 32'hDEADBEEF);
        wait_accept(2, "abort_sw");
        chk("abort_busy", 32'(req_ready[2]), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready[2]), 32'd1);
        chk("abort_valid", 32'(resp_valid[2]), 32'd0);
        chk("abort_data", read_data[2], 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        op(2, 0, SW, 0, 32'h10008010, 32'h0,        0, 32'h01020304, 4, "w3_lw_after");

        // window ending at 0xFFFFFFFF
        op(3, 1, SW, 0, 32'hFFFFFFFC, 32'hAABBCCDD, 0, 32'h0,        1, "wr_sw");
        op(3, 0, SW, 0, 32'hFFFFFFFC, 32'h0,        0, 32'hAABBCCDD, 1, "wr_lw");
        op(3, 0, SH, 1, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        0, "wr_lh_wrap");
        op(3, 0, SH, 1, 32'hFFFFFFFE, 32'h0,        0, 32'hFFFFCCDD, 1, "wr_lh_top");
        op(3, 0, SB, 1, 32'hFFFFFFFF, 32'h0,        0, 32'hFFFFFFDD, 1, "wr_lb_top");
        op(3, 0, SW, 0, 32'hFFFFFBFC, 32'h0,        1, 32'h0,        0, "wr_lw_below");

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
